// File: rtl/par2ser_pkg.sv
// Shared defaults and types for the pair-to-serial quantizer.
// The parameterised RTL moves quantized pairs as flat {hi, lo} vectors laid out like qpair_t.
package par2ser_pkg;

  localparam int DEF_IN_W  = 64;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 15;
  localparam int DEF_DEPTH = 4;
  localparam int SAT_CNT_W = 16;

  typedef enum logic {
    PH_LO,
    PH_HI
  } phase_e;

  typedef struct packed {
    logic signed [DEF_OUT_W-1:0] hi;
    logic signed [DEF_OUT_W-1:0] lo;
  } qpair_t;

endpackage

// File: rtl/pair_fifo.sv
// Small synchronous FIFO of quantized sample pairs.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
module pair_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wrPtr_q;
  logic [AW:0]  rdPtr_q;
  logic         doPush;
  logic         doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/par2ser_quant.sv
// Quantizes incoming sample pairs, buffers them and serialises them as din1 then din2.
// The head pair leaves the FIFO only once its second sample reaches the output register.
module par2ser_quant
  import par2ser_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  din1,
  input  logic signed [IN_W-1:0]  din2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] dout,
  output logic [SAT_CNT_W-1:0]    sat_cnt
);

  localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT-1);
  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // Returns {saturated, value}; the extra sum bit keeps the rounding add from overflowing.
  function automatic logic [OUT_W:0] quantize(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shr;
    logic [OUT_W:0]       res;
    sum = $signed({x[IN_W-1], x} + HALF);
    shr = sum >>> SHIFT;
    if (shr > SAT_MAX)      res = {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (shr < SAT_MIN) res = {1'b1, SAT_MIN[OUT_W-1:0]};
    else                    res = {1'b0, shr[OUT_W-1:0]};
    return res;
  endfunction

  logic [OUT_W:0]             q1;
  logic [OUT_W:0]             q2;
  logic                       push;
  logic                       pop;
  logic                       load;
  logic                       fifoFull;
  logic                       fifoEmpty;
  logic [2*OUT_W-1:0]         headPair;
  logic [1:0]                 satInc;
  logic [SAT_CNT_W:0]         satSum;
  logic [SAT_CNT_W-1:0]       satCnt_q;
  logic [SAT_CNT_W-1:0]       satCnt_d;
  logic signed [OUT_W-1:0]    dout_q;
  logic                       outValid_q;
  phase_e                     phase_q;

  assign q1       = quantize(din1);
  assign q2       = quantize(din2);
  assign in_ready = !fifoFull;
  assign push     = in_valid && !fifoFull;

  always_comb begin
    load = (!outValid_q || out_ready) && !fifoEmpty;
    pop  = load && (phase_q == PH_HI);
  end

  pair_fifo #(
    .W     (2*OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({q2[OUT_W-1:0], q1[OUT_W-1:0]}),
    .pop_i   (pop),
    .rdata_o (headPair),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Saturation counter clamps at all-ones instead of wrapping.
  always_comb begin
    satInc   = {1'b0, q1[OUT_W]} + {1'b0, q2[OUT_W]};
    satSum   = {1'b0, satCnt_q} + (SAT_CNT_W+1)'(satInc);
    satCnt_d = satCnt_q;
    if (push) satCnt_d = satSum[SAT_CNT_W] ? '1 : satSum[SAT_CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) satCnt_q <= '0;
    else     satCnt_q <= satCnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_LO;
      dout_q     <= '0;
      outValid_q <= 1'b0;
    end else if (load) begin
      outValid_q <= 1'b1;
      if (phase_q == PH_LO) begin
        dout_q  <= headPair[OUT_W-1:0];
        phase_q <= PH_HI;
      end else begin
        dout_q  <= headPair[2*OUT_W-1:OUT_W];
        phase_q <= PH_LO;
      end
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign dout      = dout_q;
  assign out_valid = outValid_q;
  assign sat_cnt   = satCnt_q;

endmodule

// File: tb/tb_par2ser_quant.sv
// Bench for par2ser_quant: a reference quantizer plus a sample queue predicts the serial stream,
// and directed scenarios pin rounding, saturation, backpressure and mid-stream reset.
module tb_par2ser_quant;

  localparam int SHIFT = 15;
  localparam logic signed [65:0] SCALE = 66'sd1 <<< SHIFT;
  localparam logic signed [65:0] HALFS = 66'sd1 <<< (SHIFT-1);
  localparam logic signed [65:0] QMAX  = 66'sd32767;
  localparam logic signed [65:0] QMIN  = -66'sd32768;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [63:0] din1;
  logic signed [63:0] din2;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] dout;
  logic [15:0]        sat_cnt;

  int checks   = 0;
  int failures = 0;

  logic signed [15:0] expQ[$];
  longint             gotLog[$];
  int                 modelSat = 0;
  bit                 streamOn = 0;

  par2ser_quant dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din1      (din1),
    .din2      (din2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .sat_cnt   (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Floor-divide by 2^SHIFT, bump when the remainder is at least half, then clamp.
  function automatic logic signed [15:0] modelQuant(input logic signed [63:0] x, output bit sat);
    logic signed [65:0] xe;
    logic signed [65:0] q;
    logic signed [65:0] r;
    xe = 66'(x);
    q  = xe / SCALE;
    r  = xe - q * SCALE;
    if (r < 0) begin
      q = q - 66'sd1;
      r = r + SCALE;
    end
    if (r >= HALFS) q = q + 66'sd1;
    sat = 1'b0;
    if (q > QMAX) begin
      q = QMAX;
      sat = 1'b1;
    end else if (q < QMIN) begin
      q = QMIN;
      sat = 1'b1;
    end
    return q[15:0];
  endfunction

  // Sampled on the falling edge, so the handshakes seen here complete on the next rising edge.
  initial begin
    bit s1;
    bit s2;
    bit avail;
    logic signed [15:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        expQ.delete();
        modelSat = 0;
      end else begin
        checkOutput("satCnt", longint'(sat_cnt), longint'(modelSat));
        if (out_valid && out_ready) begin
          avail = (expQ.size() != 0);
          checkOutput("expAvail", longint'(avail), 1);
          if (avail) begin
            e = expQ.pop_front();
            checkOutput("streamDout", longint'(dout), longint'(e));
          end
          gotLog.push_back(longint'(dout));
        end
        if (in_valid && in_ready) begin
          expQ.push_back(modelQuant(din1, s1));
          expQ.push_back(modelQuant(din2, s2));
          modelSat = modelSat + int'(s1) + int'(s2);
          if (modelSat > 65535) modelSat = 65535;
        end
      end
    end
  end

  task automatic applyStimulus(input logic signed [63:0] d1, input logic signed [63:0] d2,
                               input int maxWait);
    bit accepted;
    accepted = 1'b0;
    din1 = d1;
    din2 = d2;
    in_valid = 1'b1;
    for (int i = 0; i < maxWait && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("inAcceptTimeout", longint'(accepted), 1);
  endtask

  task automatic waitLog(input int target, input int maxWait);
    for (int i = 0; i < maxWait && gotLog.size() < target; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("logCount", longint'(gotLog.size()), longint'(target));
  endtask

  function automatic logic signed [63:0] genSample();
    logic signed [63:0] v;
    case ($urandom_range(0, 3))
      0: v = 64'(signed'($urandom));
      1: v = (64'(longint'($urandom_range(0, 4000))) - 64'sd2000) * 64'sd32768 + 64'sd16384;
      2: v = {$urandom, $urandom};
      default: begin
        v = 64'sd32767 * 64'sd32768 + 64'(longint'($urandom_range(0, 65535)));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  initial begin
    int base;
    int accepted;
    bit dummy;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    din1 = '0;
    din2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rstOutValid", longint'(out_valid), 0);
    checkOutput("rstDout", longint'(dout), 0);
    checkOutput("rstSatCnt", longint'(sat_cnt), 0);
    checkOutput("rstInReady", longint'(in_ready), 1);

    checkOutput("modelHalfUp", longint'(modelQuant(64'sd16384, dummy)), 1);
    checkOutput("modelNegHalf", longint'(modelQuant(-64'sd16384, dummy)), 0);
    checkOutput("modelNegBelowHalf", longint'(modelQuant(-64'sd16385, dummy)), -1);
    checkOutput("modelSatHi", longint'(modelQuant(64'sd1 <<< 40, dummy)), 32767);

    // Rounding, with first-sample latency measured on the first pair.
    @(posedge clk);
    #1;
    base = gotLog.size();
    out_ready = 1'b1;
    din1 = 64'sd32768;
    din2 = 64'sd16384;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("latInReady", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("latNotYet", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    checkOutput("latOutValid", longint'(out_valid), 1);
    checkOutput("latDout", longint'(dout), 1);
    applyStimulus(-64'sd16384, -64'sd16385, 20);
    waitLog(base + 4, 50);
    if (gotLog.size() >= base + 4) begin
      checkOutput("round0", gotLog[base], 1);
      checkOutput("round1", gotLog[base+1], 1);
      checkOutput("round2", gotLog[base+2], 0);
      checkOutput("round3", gotLog[base+3], -1);
    end
    checkOutput("roundSatCnt", longint'(sat_cnt), 0);

    // Saturation in both directions.
    base = gotLog.size();
    applyStimulus(64'sd1 <<< 40, -(64'sd1 <<< 40), 20);
    waitLog(base + 2, 50);
    if (gotLog.size() >= base + 2) begin
      checkOutput("satPos", gotLog[base], 32767);
      checkOutput("satNeg", gotLog[base+1], -32768);
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("satCount2", longint'(sat_cnt), 2);

    // Backpressure: only four pairs fit while the output is stalled.
    out_ready = 1'b0;
    base = gotLog.size();
    accepted = 0;
    din1 = 64'sd1 * 64'sd32768;
    din2 = 64'sd2 * 64'sd32768;
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk);
      #1;
      din1 = 64'(longint'(2 * accepted + 1)) * 64'sd32768;
      din2 = 64'(longint'(2 * accepted + 2)) * 64'sd32768;
    end
    checkOutput("bpAccepted", longint'(accepted), 4);
    checkOutput("bpInReady", longint'(in_ready), 0);
    checkOutput("bpOutValid", longint'(out_valid), 1);
    checkOutput("bpHeldDout", longint'(dout), 1);
    out_ready = 1'b1;
    applyStimulus(64'sd9 * 64'sd32768 - 64'sd4 * 64'sd32768, 64'sd10 * 64'sd32768, 40);
    applyStimulus(64'sd11 * 64'sd32768, 64'sd12 * 64'sd32768, 40);
    waitLog(base + 12, 100);
    if (gotLog.size() >= base + 12)
      for (int k = 0; k < 8; k++)
        checkOutput($sformatf("bpOrder%0d", k), gotLog[base+k], longint'(k + 1));

    // Random streaming with a 70% downstream ready rate.
    base = gotLog.size();
    streamOn = 1'b1;
    fork
      begin
        while (streamOn) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join_none
    for (int p = 0; p < 1000; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(genSample(), genSample(), 200);
    end
    streamOn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    out_ready = 1'b1;
    waitLog(base + 2000, 500);
    checkOutput("streamDrained", longint'(expQ.size()), 0);

    // Reset while three pairs sit buffered and the phase points at din2.
    out_ready = 1'b0;
    applyStimulus(64'sd1 <<< 40, 64'sd3 * 64'sd32768, 20);
    applyStimulus(64'sd5 * 64'sd32768, 64'sd6 * 64'sd32768, 20);
    applyStimulus(64'sd7 * 64'sd32768, 64'sd8 * 64'sd32768, 20);
    checkOutput("preRstOutValid", longint'(out_valid), 1);
    checkOutput("preRstDout", longint'(dout), 32767);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", longint'(out_valid), 0);
    checkOutput("midRstSatCnt", longint'(sat_cnt), 0);
    checkOutput("midRstDout", longint'(dout), 0);
    checkOutput("midRstInReady", longint'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    base = gotLog.size();
    applyStimulus(64'sd32768, 64'sd65536, 20);
    waitLog(base + 2, 50);
    if (gotLog.size() >= base + 2) begin
      checkOutput("postRst0", gotLog[base], 1);
      checkOutput("postRst1", gotLog[base+1], 2);
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput("postRstNoExtra", longint'(gotLog.size()), longint'(base + 2));
    checkOutput("postRstIdle", longint'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
